// File: rtl/dma_if.sv
// Command, host-stream and unified-buffer signals of the DMA engine.
// master drives commands, host beats and UB read data; slave is the engine.
interface dma_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
);
    logic              dma_start;
    logic              dma_dir;
    logic [ADDR_W-1:0] dma_ub_addr;
    logic [LEN_W-1:0]  dma_length;
    logic [1:0]        dma_elem_sz;
    logic              dma_busy;
    logic              dma_done;
    logic              dma_err;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              ub_wr_en;
    logic [ADDR_W-1:0] ub_wr_addr;
    logic [DATA_W-1:0] ub_wr_data;
    logic              ub_rd_en;
    logic [ADDR_W-1:0] ub_rd_addr;
    logic [DATA_W-1:0] ub_rd_data;

    modport master (
        output dma_start, dma_dir, dma_ub_addr, dma_length, dma_elem_sz,
        output in_valid, in_data, out_ready, ub_rd_data,
        input  dma_busy, dma_done, dma_err, in_ready, out_valid, out_data,
        input  ub_wr_en, ub_wr_addr, ub_wr_data, ub_rd_en, ub_rd_addr
    );

    modport slave (
        input  dma_start, dma_dir, dma_ub_addr, dma_length, dma_elem_sz,
        input  in_valid, in_data, out_ready, ub_rd_data,
        output dma_busy, dma_done, dma_err, in_ready, out_valid, out_data,
        output ub_wr_en, ub_wr_addr, ub_wr_data, ub_rd_en, ub_rd_addr
    );
endinterface

// File: rtl/dma_engine.sv
// DMA responder: host beats are written to UB in the accepting cycle; UB reads feed a 2-entry
// skid FIFO (first beat at T+2, 1 beat/cycle), reads stall while out_ready holds the FIFO full.
module dma_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic clk,
    input  logic rst,
    dma_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    localparam logic [LEN_W+1:0] RND = 3;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  beats;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  moved;
    logic              inflight;
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] fifo_q [2];
    logic              busy_q, done_q, err_q, in_rdy_q;

    logic [LEN_W+1:0]  bytes_len;
    logic [LEN_W-1:0]  cmd_beats;
    logic              wr_hs, issue, rd_vld, pop, pop_fifo, push, push_idx;

    always_comb begin
        bytes_len = {2'b00, bus.dma_length} << bus.dma_elem_sz;
        cmd_beats = LEN_W'((bytes_len + RND) >> 2);
        wr_hs     = (state == WR) & in_rdy_q & bus.in_valid;
        issue     = (state == RD) & (issued < beats) & ((fifo_cnt + {1'b0, inflight}) < 2'd2);
        rd_vld    = (fifo_cnt != 2'd0) | inflight;
        pop       = rd_vld & bus.out_ready;
        pop_fifo  = pop & (fifo_cnt != 2'd0);
        // Returning data bypasses the FIFO when it is empty and the host takes it at once.
        push      = inflight & ~(pop & (fifo_cnt == 2'd0));
        push_idx  = (fifo_cnt == 2'd2) | ((fifo_cnt == 2'd1) & ~pop_fifo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            beats     <= '0;
            issued    <= '0;
            moved     <= '0;
            inflight  <= 1'b0;
            fifo_cnt  <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= bus.dma_start & ((state != IDLE) | (bus.dma_elem_sz == 2'd3));
            inflight <= issue;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop_fifo};
            if (pop_fifo) fifo_q[0] <= fifo_q[1];
            if (push) fifo_q[push_idx] <= bus.ub_rd_data;
            if (issue) begin
                addr   <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.dma_start && bus.dma_elem_sz != 2'd3) begin
                        addr   <= bus.dma_ub_addr;
                        beats  <= cmd_beats;
                        issued <= '0;
                        moved  <= '0;
                        if (cmd_beats == '0) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else if (bus.dma_dir) begin
                            state  <= RD;
                            busy_q <= 1'b1;
                        end else begin
                            state    <= WR;
                            busy_q   <= 1'b1;
                            in_rdy_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        addr  <= addr + 1'b1;
                        moved <= moved + 1'b1;
                        if (moved == beats - 1'b1) begin
                            state    <= FIN;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            in_rdy_q <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (pop) begin
                        moved <= moved + 1'b1;
                        if (moved == beats - 1'b1) begin
                            state  <= FIN;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dma_busy   = busy_q;
    assign bus.dma_done   = done_q;
    assign bus.dma_err    = err_q;
    assign bus.in_ready   = in_rdy_q;
    assign bus.ub_wr_en   = wr_hs;
    assign bus.ub_wr_addr = addr;
    assign bus.ub_wr_data = wr_hs ? bus.in_data : '0;
    assign bus.ub_rd_en   = issue;
    assign bus.ub_rd_addr = addr;
    assign bus.out_valid  = rd_vld;
    assign bus.out_data   = (fifo_cnt != 2'd0) ? fifo_q[0] : (inflight ? bus.ub_rd_data : '0);
endmodule

// File: tb/tb_dma_engine.sv
// Randomised bench for dma_engine: a UB memory model, a reference memory and expectation queues,
// with a negedge monitor that checks every UB write and every host-side pop against the queues.
module tb_dma_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    dma_if #(.DATA_W(32), .ADDR_W(8), .LEN_W(16)) bus ();
    dma_engine #(.DATA_W(32), .ADDR_W(8), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] ub_mem  [256];
    logic [31:0] ref_mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_dat = 32'd0;

    int          exp_wr_a [$];
    logic [31:0] exp_wr_d [$];
    logic [31:0] exp_out  [$];
    logic [31:0] wdata_ovr[$];
    int          rd_exp = 0;
    int          rd_seen = 0;

    // UB model: one-cycle read latency, garbage on the read bus when no read was issued.
    always @(posedge clk) begin
        if (pre_en) ub_mem[pre_addr] <= pre_dat;
        else if (bus.ub_wr_en) ub_mem[bus.ub_wr_addr] <= bus.ub_wr_data;
        bus.ub_rd_data <= bus.ub_rd_en ? ub_mem[bus.ub_rd_addr] : $urandom;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_eq(input string name, input int act, input int exp);
        chk(act == exp, name, act, exp);
    endtask

    // Monitor
    initial begin
        int rd_iss, rd_pop;
        bit hold;
        logic [31:0] hold_dat;
        rd_iss = 0; rd_pop = 0; hold = 0; hold_dat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_iss = 0; rd_pop = 0; hold = 0;
            end else begin
                if (bus.ub_wr_en) begin
                    chk(exp_wr_a.size() != 0, "ub_wr_unexpected", 32'(bus.ub_wr_addr), 0);
                    if (exp_wr_a.size() != 0) begin
                        chk_eq("ub_wr_addr", 32'(bus.ub_wr_addr), exp_wr_a.pop_front());
                        chk_eq("ub_wr_data", bus.ub_wr_data, exp_wr_d.pop_front());
                    end
                end
                if (bus.ub_rd_en) begin
                    rd_seen++;
                    rd_iss++;
                    chk(rd_seen <= rd_exp, "ub_rd_unexpected", rd_seen, rd_exp);
                    chk(!bus.ub_wr_en, "rd_wr_overlap", 32'(bus.ub_wr_en), 0);
                    chk(rd_iss - rd_pop <= 2, "outstanding_reads", rd_iss - rd_pop, 2);
                end
                if (hold) begin
                    chk_eq("out_valid_hold", 32'(bus.out_valid), 1);
                    chk_eq("out_data_hold", bus.out_data, hold_dat);
                end
                if (bus.out_valid && bus.out_ready) begin
                    rd_pop++;
                    chk(exp_out.size() != 0, "out_unexpected", bus.out_data, 0);
                    if (exp_out.size() != 0) chk_eq("out_data", bus.out_data, exp_out.pop_front());
                end
                hold = bus.out_valid && !bus.out_ready;
                hold_dat = bus.out_data;
            end
        end
    end

    function automatic bit pace(input int mode, input int k);
        logic [4:0] p;
        p = 5'b11001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k < 5) ? p[k] : 1'($urandom_range(0, 1));
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = 8'(a); pre_dat = d; ref_mem[a] = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk_eq({tag, "_busy"},     32'(bus.dma_busy), 0);
        chk_eq({tag, "_done"},     32'(bus.dma_done), 0);
        chk_eq({tag, "_err"},      32'(bus.dma_err), 0);
        chk_eq({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk_eq({tag, "_out_vld"},  32'(bus.out_valid), 0);
        chk_eq({tag, "_out_data"}, bus.out_data, 0);
        chk_eq({tag, "_wr_en"},    32'(bus.ub_wr_en), 0);
        chk_eq({tag, "_wr_addr"},  32'(bus.ub_wr_addr), 0);
        chk_eq({tag, "_wr_data"},  bus.ub_wr_data, 0);
        chk_eq({tag, "_rd_en"},    32'(bus.ub_rd_en), 0);
        chk_eq({tag, "_rd_addr"},  32'(bus.ub_rd_addr), 0);
    endtask

    task automatic do_cmd(input bit dir, input int addr, input int len, input int sz,
                          input int mode, input bit inject);
        int beats, k, wi;
        bit done_seen, go;
        logic [31:0] wq[$];
        logic [31:0] d;
        beats = (len * (1 << sz) + 3) / 4;
        if (sz != 3) begin
            for (int i = 0; i < beats; i++) begin
                int a;
                a = (addr + i) % 256;
                if (!dir) begin
                    d = (wdata_ovr.size() != 0) ? wdata_ovr.pop_front() : $urandom;
                    wq.push_back(d);
                    exp_wr_a.push_back(a);
                    exp_wr_d.push_back(d);
                    ref_mem[a] = d;
                end else begin
                    exp_out.push_back(ref_mem[a]);
                    rd_exp++;
                end
            end
        end
        @(posedge clk); #1;
        bus.dma_start = 1'b1; bus.dma_dir = dir; bus.dma_ub_addr = 8'(addr);
        bus.dma_length = 16'(len); bus.dma_elem_sz = 2'(sz);
        bus.in_valid = 1'b0; bus.out_ready = (mode == 0);
        @(posedge clk); #1;
        bus.dma_start = 1'b0; bus.dma_dir = 1'($urandom); bus.dma_ub_addr = 8'($urandom);
        bus.dma_length = 16'($urandom); bus.dma_elem_sz = 2'($urandom);
        @(negedge clk);
        if (sz == 3) begin
            chk_eq("rsv_err", 32'(bus.dma_err), 1);
            chk_eq("rsv_busy", 32'(bus.dma_busy), 0);
            chk_eq("rsv_done", 32'(bus.dma_done), 0);
        end else if (beats == 0) begin
            chk_eq("zlen_done", 32'(bus.dma_done), 1);
            chk_eq("zlen_busy", 32'(bus.dma_busy), 0);
            chk_eq("zlen_in_ready", 32'(bus.in_ready), 0);
        end else begin
            chk_eq("start_busy", 32'(bus.dma_busy), 1);
            chk_eq("start_err", 32'(bus.dma_err), 0);
            chk_eq("start_out_vld", 32'(bus.out_valid), 0);
        end
        if (sz != 3 && beats > 0) begin
            k = 0; wi = 0; done_seen = 0;
            while (!done_seen && k < 2000) begin
                @(posedge clk); #1;
                bus.dma_start = 1'b0;
                if (inject && k == 1) begin
                    bus.dma_start = 1'b1; bus.dma_dir = ~dir; bus.dma_length = 16'd3;
                    bus.dma_elem_sz = 2'd2; bus.dma_ub_addr = 8'(addr + 100);
                end
                go = pace(mode, k);
                bus.in_valid = !dir && (wi < beats) && go;
                bus.in_data = (!dir && wi < beats) ? wq[wi] : $urandom;
                bus.out_ready = go;
                @(negedge clk);
                k++;
                if (inject && k == 3) chk_eq("busy_start_err", 32'(bus.dma_err), 1);
                if (bus.in_valid && bus.in_ready) wi++;
                if (bus.dma_done) done_seen = 1;
            end
            chk(done_seen, "done_timeout", k, 2000);
            if (mode == 0) chk_eq("done_latency", k, beats + 1);
            chk_eq("fin_busy", 32'(bus.dma_busy), 0);
            chk_eq("fin_in_ready", 32'(bus.in_ready), 0);
            chk_eq("fin_out_vld", 32'(bus.out_valid), 0);
            chk_eq("writes_left", exp_wr_a.size(), 0);
            chk_eq("reads_left", exp_out.size(), 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk_eq("post_done", 32'(bus.dma_done), 0);
        chk_eq("post_err", 32'(bus.dma_err), 0);
        chk_eq("post_busy", 32'(bus.dma_busy), 0);
    endtask

    task automatic reset_mid_read();
        int n, c;
        for (int i = 0; i < 4; i++) begin
            exp_out.push_back(ref_mem[8'h50 + i]);
            rd_exp++;
        end
        @(posedge clk); #1;
        bus.dma_start = 1'b1; bus.dma_dir = 1'b1; bus.dma_ub_addr = 8'h50;
        bus.dma_length = 16'd4; bus.dma_elem_sz = 2'd2; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.dma_start = 1'b0;
        n = 0; c = 0;
        while (n < 1 && c < 20) begin
            @(negedge clk);
            c++;
            if (bus.out_valid && bus.out_ready) n++;
        end
        chk_eq("rst_first_pop", n, 1);
        @(posedge clk); #1;
        rst = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        exp_out.delete();
        rd_exp = rd_seen;
    endtask

    initial begin
        bus.dma_start = 1'b0; bus.dma_dir = 1'b0; bus.dma_ub_addr = 8'd0;
        bus.dma_length = 16'd0; bus.dma_elem_sz = 2'd0;
        bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        for (int i = 0; i < 256; i++) preload(i, $urandom);
        for (int i = 0; i < 4; i++) preload(8'h20 + i, 32'(i + 1));

        wdata_ovr.push_back(32'hA1A2A3A4);
        wdata_ovr.push_back(32'hB1B2B3B4);
        do_cmd(1'b0, 8'h10, 8, 0, 0, 1'b0);
        do_cmd(1'b1, 8'h10, 8, 0, 0, 1'b0);

        do_cmd(1'b1, 8'h20, 4, 2, 1, 1'b0);
        do_cmd(1'b1, 8'h20, 4, 2, 0, 1'b0);

        do_cmd(1'b0, 8'hFE, 5, 1, 2, 1'b0);
        do_cmd(1'b1, 8'hFE, 5, 1, 0, 1'b0);

        do_cmd(1'b0, 8'h30, 0, 1, 0, 1'b0);
        do_cmd(1'b1, 8'h30, 7, 3, 0, 1'b0);
        do_cmd(1'b0, 8'h40, 24, 0, 0, 1'b1);
        do_cmd(1'b1, 8'h40, 24, 0, 2, 1'b0);

        reset_mid_read();
        do_cmd(1'b1, 8'h50, 4, 2, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int sz;
            sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 12),
                   sz, $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
